// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: time-shares one shift-add multiplier between two requesters.
// Each job clears the multiplier, starts it and waits for its done flag. The
// 2*WIDTH product goes back on a shared result bus tagged with the owner id.
// A watchdog aborts a job whose done flag never arrives.
//
// Request/result handshake: reqN is a level. A requester keeps reqN high until
// it sees res_valid with res_id == N. res_valid is a single-cycle strobe with
// no back-pressure. A reqN still high in the IDLE cycle after DONE starts a
// new job. When both requesters keep asking, service alternates between them.
module mul_share_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               res_valid,
  output logic               res_id,
  output logic               res_err,
  output logic [2*WIDTH-1:0] res_prod,
  output logic               mul_rst,
  output logic               mul_run,
  output logic [WIDTH-1:0]   mul_mcand,
  output logic [WIDTH-1:0]   mul_mplier,
  input  logic               mul_rdy,
  input  logic [2*WIDTH-1:0] mul_prod,
  output logic [2:0]         state_dbg
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic              win_id;
  logic              last_id;
  logic              pick;
  logic              err_q;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              busy;

  // Round-robin choice: a tie goes to the requester not served last time.
  always_comb begin
    pick = req1;
    if (req0 && req1) pick = ~last_id;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic. In WAIT the done flag takes priority over the watchdog.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 || req1) state_nxt = CLR;
      CLR:     state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (mul_rdy || (cnt == LAST)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Job registers: winner and operands, watchdog count, outcome, product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_id   <= 1'b0;
      last_id  <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      err_q    <= 1'b0;
      res_prod <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            win_id <= pick;
            a_q    <= pick ? a1 : a0;
            b_q    <= pick ? b1 : b0;
          end
        end
        START: cnt <= '0;
        WAIT: begin
          if (mul_rdy) begin
            res_prod <= mul_prod;
            err_q    <= 1'b0;
          end else if (cnt == LAST) begin
            res_prod <= '0;
            err_q    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: last_id <= win_id;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state, so reset clears them immediately.
  always_comb begin
    busy       = (state != IDLE);
    gnt0       = busy && !win_id;
    gnt1       = busy && win_id;
    mul_rst    = (state == CLR);
    mul_run    = (state == START);
    res_valid  = (state == DONE);
    res_id     = res_valid ? win_id : 1'b0;
    res_err    = res_valid ? err_q  : 1'b0;
    mul_mcand  = busy ? a_q : '0;
    mul_mplier = busy ? b_q : '0;
    state_dbg  = state;
  end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl with a behavioural shift-add multiplier
// model whose done latency can be set per test or suppressed entirely.
module tb_mul_share_ctrl;

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, res_valid, res_id, res_err;
  logic [63:0] res_prod;
  logic        mul_rst, mul_run;
  logic [31:0] mul_mcand, mul_mplier;
  logic        mul_rdy;
  logic [63:0] mul_prod;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mul_share_ctrl #(.WIDTH(32), .TIMEOUT(40)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1),
    .res_valid(res_valid), .res_id(res_id), .res_err(res_err), .res_prod(res_prod),
    .mul_rst(mul_rst), .mul_run(mul_run),
    .mul_mcand(mul_mcand), .mul_mplier(mul_mplier),
    .mul_rdy(mul_rdy), .mul_prod(mul_prod),
    .state_dbg(state_dbg)
  );

  // ---------------- multiplier model ----------------
  // Cleared by mul_rst; on mul_run latches operands and raises rdy mdl_delay
  // edges later (never, when mdl_never is set). rdy stays up until cleared.
  int          mdl_delay = 33;
  bit          mdl_never = 1'b0;
  int          mdl_cnt;
  logic [63:0] mdl_op;

  initial begin
    mul_rdy  = 1'b0;
    mul_prod = 64'd0;
    mdl_cnt  = 0;
    mdl_op   = 64'd0;
  end

  always @(posedge clk) begin
    if (mul_rst) begin
      mul_rdy  <= 1'b0;
      mdl_cnt  <= 0;
      mul_prod <= 64'd0;
    end else if (mul_run) begin
      mdl_cnt  <= mdl_never ? 0 : mdl_delay;
      mdl_op   <= {32'd0, mul_mcand} * {32'd0, mul_mplier};
      mul_prod <= 64'd0;
    end else if (mdl_cnt == 1) begin
      mul_rdy  <= 1'b1;
      mul_prod <= mdl_op;
      mdl_cnt  <= 0;
    end else if (mdl_cnt > 1) begin
      mdl_cnt <= mdl_cnt - 1;
    end
  end

  // ---------------- activity monitor ----------------
  // Cumulative counts; tests compare differences taken around a job.
  int n_mrst = 0, n_mrun = 0, n_valid = 0, n_wait = 0;
  int n_gnt0 = 0, n_gnt1 = 0, n_overlap = 0, n_idle_op = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (mul_rst)   n_mrst++;
      if (mul_run)   n_mrun++;
      if (res_valid) n_valid++;
      if (gnt0)      n_gnt0++;
      if (gnt1)      n_gnt1++;
      if (gnt0 && gnt1) n_overlap++;
      if ((gnt0 || gnt1) && !mul_rst && !mul_run && !res_valid) n_wait++;
      if (!gnt0 && !gnt1 && (mul_mcand != 32'd0 || mul_mplier != 32'd0)) n_idle_op++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_result(input int max_cyc, output bit got, output logic id,
                             output logic err, output logic [63:0] prod);
    got  = 1'b0;
    id   = 1'b0;
    err  = 1'b0;
    prod = 64'd0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        got  = 1'b1;
        id   = res_id;
        err  = res_err;
        prod = res_prod;
      end
    end
  endtask

  // Lets the monitor finish counting the current cycle.
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt0, gnt1, res_valid, res_id, res_err, mul_rst, mul_run} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctl: got %b expected 0000000",
               {gnt0, gnt1, res_valid, res_id, res_err, mul_rst, mul_run});
    end
    checks++;
    if ({res_prod, mul_mcand, mul_mplier} !== 128'd0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h/%h expected 0", res_prod, mul_mcand, mul_mplier);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt0, gnt1, mul_rst} !== 3'b000) begin
      errors++;
      $display("FAIL idle_no_req: got %b expected 000", {gnt0, gnt1, mul_rst});
    end
  endtask

  task automatic test_single();
    bit got; logic id, err; logic [63:0] prod;
    int s_mrst, s_mrun, s_wait, s_g0, s_g1;
    settle();
    s_mrst = n_mrst; s_mrun = n_mrun; s_wait = n_wait; s_g0 = n_gnt0; s_g1 = n_gnt1;
    mdl_delay = 33;
    a0 = 32'd3; b0 = 32'd5; req0 = 1'b1;
    wait_result(200, got, id, err, prod);
    req0 = 1'b0; a0 = '0; b0 = '0;
    settle();
    checks++;
    if (!got) begin errors++; $display("FAIL single_timeout: got no res_valid expected one"); end
    checks++;
    if ({id, err, prod} !== {1'b0, 1'b0, 64'd15}) begin
      errors++;
      $display("FAIL single_result: got id=%0d err=%0d prod=%0h expected id=0 err=0 prod=f", id, err, prod);
    end
    checks++;
    if ((n_mrst - s_mrst) != 1 || (n_mrun - s_mrun) != 1) begin
      errors++;
      $display("FAIL single_pulses: got rst=%0d run=%0d expected 1/1", n_mrst - s_mrst, n_mrun - s_mrun);
    end
    checks++;
    if ((n_wait - s_wait) != 34) begin
      errors++;
      $display("FAIL single_wait: got %0d expected 34", n_wait - s_wait);
    end
    checks++;
    if ((n_gnt0 - s_g0) != 37 || (n_gnt1 - s_g1) != 0) begin
      errors++;
      $display("FAIL single_gnt: got g0=%0d g1=%0d expected 37/0", n_gnt0 - s_g0, n_gnt1 - s_g1);
    end
  endtask

  task automatic test_alternate();
    bit got; logic id, err; logic [63:0] prod;
    logic        exp_id   [4];
    logic [63:0] exp_prod [4];
    exp_id   = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_prod = '{64'd42, 64'h1_FFFF_FFFE, 64'd42, 64'h1_FFFF_FFFE};
    @(negedge clk);
    rst = 1'b0;
    a0 = 32'd7; b0 = 32'd6; a1 = 32'hFFFF_FFFF; b1 = 32'd2;
    req0 = 1'b1; req1 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_result(200, got, id, err, prod);
      if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
      checks++;
      if (!got || id !== exp_id[k] || err !== 1'b0 || prod !== exp_prod[k]) begin
        errors++;
        $display("FAIL alt_%0d: got v=%0d id=%0d err=%0d prod=%0h expected v=1 id=%0d err=0 prod=%0h",
                 k, got, id, err, prod, exp_id[k], exp_prod[k]);
      end
    end
    settle();
    checks++;
    if (n_overlap != 0 || n_idle_op != 0) begin
      errors++;
      $display("FAIL alt_gnt_ops: got overlap=%0d idle_ops=%0d expected 0/0", n_overlap, n_idle_op);
    end
  endtask

  task automatic test_max_operands();
    bit got; logic id, err; logic [63:0] prod;
    a1 = 32'hFFFF_FFFF; b1 = 32'hFFFF_FFFF; req1 = 1'b1;
    wait_result(200, got, id, err, prod);
    req1 = 1'b0;
    checks++;
    if (!got || {id, err, prod} !== {1'b1, 1'b0, 64'hFFFF_FFFE_0000_0001}) begin
      errors++;
      $display("FAIL max_ops: got v=%0d id=%0d err=%0d prod=%0h expected v=1 id=1 err=0 prod=fffffffe00000001",
               got, id, err, prod);
    end
  endtask

  task automatic test_timeout();
    bit got; logic id, err; logic [63:0] prod;
    int s_wait;
    settle();
    s_wait = n_wait;
    mdl_never = 1'b1;
    a0 = 32'd9; b0 = 32'd9; req0 = 1'b1;
    wait_result(200, got, id, err, prod);
    req0 = 1'b0;
    settle();
    checks++;
    if (!got || {id, err, prod} !== {1'b0, 1'b1, 64'd0}) begin
      errors++;
      $display("FAIL timeout_result: got v=%0d id=%0d err=%0d prod=%0h expected v=1 id=0 err=1 prod=0",
               got, id, err, prod);
    end
    checks++;
    if ((n_wait - s_wait) != 40) begin
      errors++;
      $display("FAIL timeout_wait: got %0d expected 40", n_wait - s_wait);
    end
    mdl_never = 1'b0;
    repeat (2) @(negedge clk);
    a0 = 32'd2; b0 = 32'd3; req0 = 1'b1;
    wait_result(200, got, id, err, prod);
    req0 = 1'b0;
    checks++;
    if (!got || {id, err, prod} !== {1'b0, 1'b0, 64'd6}) begin
      errors++;
      $display("FAIL after_timeout: got v=%0d id=%0d err=%0d prod=%0h expected v=1 id=0 err=0 prod=6",
               got, id, err, prod);
    end
  endtask

  task automatic test_coincide();
    bit got; logic id, err; logic [63:0] prod;
    int s_wait;
    settle();
    s_wait = n_wait;
    mdl_delay = 39;
    a0 = 32'd100; b0 = 32'd200; req0 = 1'b1;
    wait_result(200, got, id, err, prod);
    req0 = 1'b0;
    settle();
    mdl_delay = 33;
    checks++;
    if (!got || {id, err, prod} !== {1'b0, 1'b0, 64'd20000}) begin
      errors++;
      $display("FAIL coincide_result: got v=%0d id=%0d err=%0d prod=%0h expected v=1 id=0 err=0 prod=4e20",
               got, id, err, prod);
    end
    checks++;
    if ((n_wait - s_wait) != 40) begin
      errors++;
      $display("FAIL coincide_wait: got %0d expected 40", n_wait - s_wait);
    end
  endtask

  task automatic test_reset_mid_job();
    bit got; logic id, err; logic [63:0] prod;
    bit seen;
    int s_valid;
    settle();
    s_valid = n_valid;
    a0 = 32'd11; b0 = 32'd13; req0 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (gnt0 === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL midrst_gnt: got no gnt0 expected gnt0"); end
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b0;
    req0 = 1'b0;
    a1 = 32'd4; b1 = 32'd5; req1 = 1'b1;
    #1;
    checks++;
    if ({gnt0, gnt1, res_valid, res_id, res_err, mul_rst, mul_run} !== 7'd0 ||
        {res_prod, mul_mcand, mul_mplier} !== 128'd0) begin
      errors++;
      $display("FAIL midrst_async: got ctl=%b prod=%0h ops=%0h/%0h expected all 0",
               {gnt0, gnt1, res_valid, res_id, res_err, mul_rst, mul_run}, res_prod, mul_mcand, mul_mplier);
    end
    @(negedge clk);
    rst = 1'b1;
    wait_result(200, got, id, err, prod);
    req1 = 1'b0;
    settle();
    checks++;
    if (!got || {id, err, prod} !== {1'b1, 1'b0, 64'd20}) begin
      errors++;
      $display("FAIL midrst_next: got v=%0d id=%0d err=%0d prod=%0h expected v=1 id=1 err=0 prod=14",
               got, id, err, prod);
    end
    checks++;
    if ((n_valid - s_valid) != 1) begin
      errors++;
      $display("FAIL midrst_valid_count: got %0d expected 1", n_valid - s_valid);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_max_operands();
    test_timeout();
    test_coincide();
    test_reset_mid_job();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
